// File: rtl/rename_pkg.sv
// Shared types and sizing for the rename / retire pair.
// The top level's optional reclaim checker is enabled by defining RECLAIM_CHECK_EN.
package rename_pkg;
   localparam int PHYS_REGS      = 128;
   localparam int ARCH_REGS      = 32;
   localparam int COMMIT_W       = 8;
   localparam int RET_FIFO_DEPTH = 16;
   localparam int PHYS_W         = $clog2(PHYS_REGS);
   localparam int ARCH_W         = $clog2(ARCH_REGS);

   typedef logic [PHYS_W-1:0] phys_tag_t;
   typedef logic [ARCH_W-1:0] arch_idx_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RESTORE = 1'b1
   } restore_state_e;
endpackage

// File: rtl/ret_fifo_mw.sv
// Multi-push / multi-pop circular FIFO: up to N compacted pushes per cycle and
// N head lanes presented from registers. DEPTH must be a power of two.
module ret_fifo_mw #(
   parameter int DEPTH = 16,
   parameter int W     = 7,
   parameter int N     = 8,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0]        push_mask,
   input  logic [N-1:0][W-1:0] push_data,
   input  logic                pop,
   output logic [N-1:0]        out_valid,
   output logic [N-1:0][W-1:0] out_data,
   output logic [CW-1:0]       count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] cnt;
   logic [CW-1:0] n_push, n_pop;
   logic [PW-1:0] slot_ptr [N];

   // Each pushing slot lands at tail plus the number of pushing slots below it.
   always_comb begin
      n_push = '0;
      for (int i = 0; i < N; i++) begin
         slot_ptr[i] = tail + n_push[PW-1:0];
         if (push_mask[i]) n_push = n_push + 1'b1;
      end
   end

   always_comb begin
      for (int k = 0; k < N; k++) begin
         out_valid[k] = int'(cnt) > k;
         out_data[k]  = out_valid[k] ? mem[head + PW'(k)] : '0;
      end
      n_pop = '0;
      if (pop) n_pop = (int'(cnt) > N) ? CW'(N) : cnt;
   end

   assign count = cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (push_mask[i]) mem[slot_ptr[i]] <= push_data[i];
         end
         tail <= tail + n_push[PW-1:0];
         head <= head + n_pop[PW-1:0];
         cnt  <= cnt + n_push - n_pop;
      end
   end
endmodule

// File: rtl/retire_reclaim_8wide.sv
// Retirement map (RRAT), old-tag return FIFO and flush-time map restore.
// Define RECLAIM_CHECK_EN to add the in-flight-free bitmap and sticky error_o.
module retire_reclaim_8wide
   import rename_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [COMMIT_W-1:0]               commit_valid_i,
   input  logic [COMMIT_W-1:0]               commit_has_rd_i,
   input  logic [COMMIT_W-1:0][ARCH_W-1:0]   commit_rd_arch_i,
   input  logic [COMMIT_W-1:0][PHYS_W-1:0]   commit_rd_phys_i,
   input  logic [COMMIT_W-1:0][PHYS_W-1:0]   commit_old_phys_i,
   output logic                              commit_ready_o,
   output logic [COMMIT_W-1:0]               free_ret_valid_o,
   output logic [COMMIT_W-1:0][PHYS_W-1:0]   free_ret_phys_o,
   input  logic                              free_ready_i,
   input  logic                              flush_i,
   output logic                              restore_valid_o,
   output logic [1:0]                        restore_beat_o,
   output logic [COMMIT_W-1:0][PHYS_W-1:0]   restore_phys_o,
   output logic [4:0]                        ret_count_o,
   output logic                              error_o
);
   restore_state_e state_q, state_d;
   logic [1:0]     beat_q, beat_d;
   phys_tag_t      rrat [ARCH_REGS];
   logic [COMMIT_W-1:0] accept;

   assign commit_ready_o = (state_q == ST_IDLE) &&
                           ((RET_FIFO_DEPTH - int'(ret_count_o)) >= COMMIT_W);

   always_comb begin
      for (int i = 0; i < COMMIT_W; i++) begin
         accept[i] = commit_ready_o && commit_valid_i[i] && commit_has_rd_i[i] &&
                     (commit_rd_arch_i[i] != '0);
      end
   end

   ret_fifo_mw #(.DEPTH(RET_FIFO_DEPTH), .W(PHYS_W), .N(COMMIT_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_mask (accept),
      .push_data (commit_old_phys_i),
      .pop       (free_ready_i),
      .out_valid (free_ret_valid_o),
      .out_data  (free_ret_phys_o),
      .count     (ret_count_o)
   );

   // Ascending slot order: the last non-blocking write wins, so the youngest slot
   // targeting a register sets its mapping. Arch 0 is never accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ARCH_REGS; i++) rrat[i] <= phys_tag_t'(i);
      end else begin
         for (int i = 0; i < COMMIT_W; i++) begin
            if (accept[i]) rrat[commit_rd_arch_i[i]] <= commit_rd_phys_i[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         ST_IDLE: begin
            if (flush_i) begin
               state_d = ST_RESTORE;
               beat_d  = 2'd0;
            end
         end
         ST_RESTORE: begin
            if (beat_q == 2'd3) begin
               state_d = ST_IDLE;
               beat_d  = 2'd0;
            end else begin
               beat_d = beat_q + 2'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            beat_d  = 2'd0;
         end
      endcase
   end

   always_comb begin
      restore_valid_o = (state_q == ST_RESTORE);
      restore_beat_o  = beat_q;
      for (int k = 0; k < COMMIT_W; k++) begin
         restore_phys_o[k] = restore_valid_o ? rrat[{beat_q, 3'(k)}] : '0;
      end
   end

`ifdef RECLAIM_CHECK_EN
   logic [PHYS_REGS-1:0] inflight, set_mask, clr_mask;
   logic                 chk_err, error_q;

   // A tag is bad if zero, out of range, already awaiting reuse, or pushed twice at once.
   always_comb begin
      chk_err  = 1'b0;
      set_mask = '0;
      clr_mask = '0;
      for (int i = 0; i < COMMIT_W; i++) begin
         if (free_ready_i && free_ret_valid_o[i]) clr_mask[free_ret_phys_o[i]] = 1'b1;
         if (accept[i]) begin
            set_mask[commit_old_phys_i[i]] = 1'b1;
            if (commit_old_phys_i[i] == '0 || int'(commit_old_phys_i[i]) >= PHYS_REGS ||
                inflight[commit_old_phys_i[i]])
               chk_err = 1'b1;
            for (int j = 0; j < i; j++) begin
               if (accept[j] && commit_old_phys_i[j] == commit_old_phys_i[i]) chk_err = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= '0;
         error_q  <= 1'b0;
      end else begin
         inflight <= (inflight & ~clr_mask) | set_mask;
         error_q  <= error_q | chk_err;
      end
   end

   assign error_o = error_q;

   a_reclaim_ok: assert property (@(posedge clk) disable iff (!rst_n) !chk_err);
`else
   assign error_o = 1'b0;
`endif
endmodule

// File: tb/tb_retire_reclaim_8wide.sv
// Directed bench for retire_reclaim_8wide: vector table for single-cycle commits,
// hand-written sequences for fill/backpressure, flush restore and reset.
module tb_retire_reclaim_8wide;
   import rename_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]      commit_valid, commit_has_rd;
   logic [7:0][4:0] commit_rd_arch;
   logic [7:0][6:0] commit_rd_phys, commit_old_phys;
   logic            commit_ready;
   logic [7:0]      free_ret_valid;
   logic [7:0][6:0] free_ret_phys;
   logic            free_ready, flush;
   logic            restore_valid;
   logic [1:0]      restore_beat;
   logic [7:0][6:0] restore_phys;
   logic [4:0]      ret_count;
   logic            error;

   retire_reclaim_8wide dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .commit_valid_i    (commit_valid),
      .commit_has_rd_i   (commit_has_rd),
      .commit_rd_arch_i  (commit_rd_arch),
      .commit_rd_phys_i  (commit_rd_phys),
      .commit_old_phys_i (commit_old_phys),
      .commit_ready_o    (commit_ready),
      .free_ret_valid_o  (free_ret_valid),
      .free_ret_phys_o   (free_ret_phys),
      .free_ready_i      (free_ready),
      .flush_i           (flush),
      .restore_valid_o   (restore_valid),
      .restore_beat_o    (restore_beat),
      .restore_phys_o    (restore_phys),
      .ret_count_o       (ret_count),
      .error_o           (error)
   );

   typedef struct {
      logic [7:0]      valid;
      logic [7:0]      has_rd;
      logic [7:0][4:0] arch;
      logic [7:0][6:0] phys;
      logic [7:0][6:0] old;
      logic [7:0]      exp_lanes;
      logic [7:0][6:0] exp_tags;
      int              exp_count;
   } vec_t;

   int        n_cmp = 0;
   int        n_bad = 0;
   phys_tag_t rrat_m [ARCH_REGS];
   vec_t      vecs [4];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_commit();
      commit_valid    = '0;
      commit_has_rd   = '0;
      commit_rd_arch  = '0;
      commit_rd_phys  = '0;
      commit_old_phys = '0;
   endtask

   task automatic set_slot(input int s, input int a, input int p, input int o);
      commit_valid[s]    = 1'b1;
      commit_has_rd[s]   = 1'b1;
      commit_rd_arch[s]  = 5'(a);
      commit_rd_phys[s]  = 7'(p);
      commit_old_phys[s] = 7'(o);
   endtask

   // Call only for commits the bench expects to be accepted.
   task automatic model_commit();
      for (int i = 0; i < 8; i++) begin
         if (commit_valid[i] && commit_has_rd[i] && commit_rd_arch[i] != 5'd0)
            rrat_m[commit_rd_arch[i]] = commit_rd_phys[i];
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ARCH_REGS; i++) rrat_m[i] = phys_tag_t'(i);
   endtask

   task automatic check_beat(input int b);
      chk("restore_valid", int'(restore_valid), 1);
      chk("restore_beat", int'(restore_beat), b);
      for (int k = 0; k < 8; k++)
         chk($sformatf("restore_phys[%0d]", b * 8 + k), int'(restore_phys[k]), int'(rrat_m[b * 8 + k]));
   endtask

   task automatic flush_and_check_map();
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int b = 0; b < 4; b++) begin
         check_beat(b);
         step();
      end
      chk("restore_valid_after", int'(restore_valid), 0);
      chk("commit_ready_after", int'(commit_ready), 1);
   endtask

   function automatic vec_t blank_vec();
      vec_t v;
      v.valid = '0; v.has_rd = '0; v.arch = '0; v.phys = '0; v.old = '0;
      v.exp_lanes = '0; v.exp_tags = '0; v.exp_count = 0;
      return v;
   endfunction

   function automatic vec_t with_slot(input vec_t v, input int s, input logic has,
                                      input int a, input int p, input int o);
      vec_t r = v;
      r.valid[s] = 1'b1; r.has_rd[s] = has;
      r.arch[s] = 5'(a); r.phys[s] = 7'(p); r.old[s] = 7'(o);
      return r;
   endfunction

   initial begin
      // Slots 0,2,5 retire with old tags 40,41,42.
      vecs[0] = blank_vec();
      vecs[0] = with_slot(vecs[0], 0, 1'b1, 1, 100, 40);
      vecs[0] = with_slot(vecs[0], 2, 1'b1, 2, 101, 41);
      vecs[0] = with_slot(vecs[0], 5, 1'b1, 3, 102, 42);
      vecs[0].exp_lanes = 8'h07;
      vecs[0].exp_tags[0] = 7'd40; vecs[0].exp_tags[1] = 7'd41; vecs[0].exp_tags[2] = 7'd42;
      vecs[0].exp_count = 3;
      // arch 0 and has_rd=0 slots push nothing; slot 3 pushes 47.
      vecs[1] = blank_vec();
      vecs[1] = with_slot(vecs[1], 0, 1'b1, 0, 99, 45);
      vecs[1] = with_slot(vecs[1], 1, 1'b0, 7, 98, 46);
      vecs[1] = with_slot(vecs[1], 3, 1'b1, 9, 103, 47);
      vecs[1].exp_lanes = 8'h01;
      vecs[1].exp_tags[0] = 7'd47;
      vecs[1].exp_count = 1;
      // Full 8-wide retire.
      vecs[2] = blank_vec();
      for (int i = 0; i < 8; i++) begin
         vecs[2] = with_slot(vecs[2], i, 1'b1, 10 + i, 104 + i, 48 + i);
         vecs[2].exp_tags[i] = 7'(48 + i);
      end
      vecs[2].exp_lanes = 8'hFF;
      vecs[2].exp_count = 8;
      // Sparse high slots compact to lanes 0,1.
      vecs[3] = blank_vec();
      vecs[3] = with_slot(vecs[3], 4, 1'b1, 20, 112, 56);
      vecs[3] = with_slot(vecs[3], 6, 1'b0, 22, 114, 58);
      vecs[3] = with_slot(vecs[3], 7, 1'b1, 21, 113, 57);
      vecs[3].exp_lanes = 8'h03;
      vecs[3].exp_tags[0] = 7'd56; vecs[3].exp_tags[1] = 7'd57;
      vecs[3].exp_count = 2;

      clear_commit();
      free_ready = 1'b0;
      flush = 1'b0;
      model_reset();
      step();
      chk("rst_restore_valid", int'(restore_valid), 0);
      chk("rst_count", int'(ret_count), 0);
      step();
      rst_n = 1'b1;
      step();

      chk("reset_commit_ready", int'(commit_ready), 1);
      chk("reset_count", int'(ret_count), 0);
      chk("reset_restore_valid", int'(restore_valid), 0);
      chk("reset_restore_beat", int'(restore_beat), 0);
      chk("reset_ret_valid", int'(free_ret_valid), 0);
      chk("reset_error", int'(error), 0);
      flush_and_check_map();

      // Table: commit, see tags on lanes next cycle, then drained the cycle after.
      free_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         chk($sformatf("v%0d_ready", v), int'(commit_ready), 1);
         commit_valid    = vecs[v].valid;
         commit_has_rd   = vecs[v].has_rd;
         commit_rd_arch  = vecs[v].arch;
         commit_rd_phys  = vecs[v].phys;
         commit_old_phys = vecs[v].old;
         model_commit();
         step();
         clear_commit();
         chk($sformatf("v%0d_lanes", v), int'(free_ret_valid), int'(vecs[v].exp_lanes));
         chk($sformatf("v%0d_count", v), int'(ret_count), vecs[v].exp_count);
         for (int k = 0; k < 8; k++) begin
            if (vecs[v].exp_lanes[k])
               chk($sformatf("v%0d_tag%0d", v, k), int'(free_ret_phys[k]), int'(vecs[v].exp_tags[k]));
         end
         step();
         chk($sformatf("v%0d_drained", v), int'(ret_count), 0);
         chk($sformatf("v%0d_lanes_off", v), int'(free_ret_valid), 0);
      end
      flush_and_check_map();

      // Backpressure: two full groups fill the FIFO, the third is refused.
      free_ready = 1'b0;
      for (int i = 0; i < 8; i++) set_slot(i, 1 + i, 20 + i, 70 + i);
      model_commit();
      step();
      chk("fill8_count", int'(ret_count), 8);
      chk("fill8_ready", int'(commit_ready), 1);
      for (int i = 0; i < 8; i++) set_slot(i, 9 + i, 28 + i, 78 + i);
      model_commit();
      step();
      chk("fill16_count", int'(ret_count), 16);
      chk("fill16_ready", int'(commit_ready), 0);
      for (int i = 0; i < 8; i++) set_slot(i, 17 + i, 36 + i, 86 + i);
      step();
      clear_commit();
      chk("refused_count", int'(ret_count), 16);
      chk("refused_ready", int'(commit_ready), 0);
      chk("full_lanes", int'(free_ret_valid), 8'hFF);
      chk("full_tag0", int'(free_ret_phys[0]), 70);
      chk("full_tag7", int'(free_ret_phys[7]), 77);
      free_ready = 1'b1;
      step();
      chk("pop8_count", int'(ret_count), 8);
      chk("pop8_ready", int'(commit_ready), 1);
      chk("pop8_tag0", int'(free_ret_phys[0]), 78);
      chk("pop8_tag7", int'(free_ret_phys[7]), 85);
      step();
      chk("pop16_count", int'(ret_count), 0);
      flush_and_check_map();

      // Same-arch collision in the flush cycle: youngest slot wins, beat 0 shows it.
      set_slot(1, 5, 60, 43);
      set_slot(6, 5, 61, 44);
      flush = 1'b1;
      model_commit();
      step();
      clear_commit();
      flush = 1'b0;
      chk("collide_rrat5", int'(restore_phys[5]), 61);
      check_beat(0);
      chk("collide_lanes", int'(free_ret_valid), 8'h03);
      chk("collide_tag0", int'(free_ret_phys[0]), 43);
      chk("collide_tag1", int'(free_ret_phys[1]), 44);
      chk("restore_ready", int'(commit_ready), 0);
      step();
      chk("drain_in_restore", int'(ret_count), 0);
      check_beat(1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_beat(2);
      step();
      check_beat(3);
      step();
      chk("collide_idle", int'(restore_valid), 0);
      chk("collide_ready", int'(commit_ready), 1);

`ifdef RECLAIM_CHECK_EN
      free_ready = 1'b0;
      set_slot(0, 1, 9, 50);
      model_commit();
      step();
      chk("chk_first_push", int'(error), 0);
      model_commit();
      step();
      clear_commit();
      chk("chk_dup_push", int'(error), 1);
      free_ready = 1'b1;
      step();
      step();
      chk("chk_sticky", int'(error), 1);
      chk("chk_drained", int'(ret_count), 0);
`endif

      // Asynchronous reset in the middle of a restore.
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_beat(0);
      step();
      check_beat(1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_valid", int'(restore_valid), 0);
      chk("midrst_beat", int'(restore_beat), 0);
      for (int k = 0; k < 8; k++)
         chk($sformatf("midrst_phys%0d", k), int'(restore_phys[k]), 0);
      chk("midrst_error", int'(error), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("postrst_valid", int'(restore_valid), 0);
      chk("postrst_ready", int'(commit_ready), 1);
      chk("postrst_count", int'(ret_count), 0);
      flush_and_check_map();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
